// File: rtl/seq_player.sv
// Playback sequencer: walks register-file entries 0..len-1, lighting each colour for
// ON_CYCLES then going dark for OFF_CYCLES. Define SEQ_PLAYER_ABORT_EN to add the abort input.
module seq_player #(
    parameter int ON_CYCLES  = 4,
    parameter int OFF_CYCLES = 2,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   seq_len,
`ifdef SEQ_PLAYER_ABORT_EN
    input  logic              abort,
`endif
    output logic [ADDR_W-1:0] rd_sel,
    input  logic [DATA_W-1:0] rd_data,
    output logic              led_on,
    output logic [DATA_W-1:0] led_color,
    output logic              busy,
    output logic              done
);

    localparam int LEN_W   = ADDR_W + 1;
    localparam int CNT_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [LEN_W-1:0] DEPTH    = LEN_W'(2 ** ADDR_W);
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ON,
        ST_OFF
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   idx_reg, idx_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [LEN_W-1:0]    len_reg, len_next;
    logic                led_on_reg, led_on_next;
    logic [DATA_W-1:0]   led_color_reg, led_color_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                last_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            cnt_reg       <= '0;
            len_reg       <= '0;
            led_on_reg    <= 1'b0;
            led_color_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            cnt_reg       <= cnt_next;
            len_reg       <= len_next;
            led_on_reg    <= led_on_next;
            led_color_reg <= led_color_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    // len is never 0 outside IDLE, so len-1 cannot underflow where this is used
    assign last_step = ({1'b0, idx_reg} == (len_reg - LEN_W'(1)));

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        cnt_next       = cnt_reg;
        len_next       = len_reg;
        led_on_next    = led_on_reg;
        led_color_next = led_color_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    len_next = (seq_len > DEPTH) ? DEPTH : seq_len;
                    idx_next = '0;
                    cnt_next = '0;
                    if (seq_len == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = ST_LOAD;
                        busy_next  = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                led_color_next = rd_data;
                led_on_next    = 1'b1;
                cnt_next       = ON_LOAD;
                state_next     = ST_ON;
            end
            ST_ON: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else begin
                    led_on_next    = 1'b0;
                    led_color_next = '0;
                    cnt_next       = OFF_LOAD;
                    state_next     = ST_OFF;
                end
            end
            ST_OFF: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else if (last_step) begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = ST_IDLE;
                end else begin
                    idx_next   = idx_reg + ADDR_W'(1);
                    state_next = ST_LOAD;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

`ifdef SEQ_PLAYER_ABORT_EN
        // abort overrides whatever transition was chosen above, and suppresses done
        if (abort && (state_reg != ST_IDLE)) begin
            state_next     = ST_IDLE;
            cnt_next       = '0;
            led_on_next    = 1'b0;
            led_color_next = '0;
            busy_next      = 1'b0;
            done_next      = 1'b0;
        end
`endif
    end

    assign rd_sel    = idx_reg;
    assign led_on    = led_on_reg;
    assign led_color = led_color_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player: cycle-accurate timing model plus a colour scoreboard
// popped on each rising edge of led_on.
module tb_seq_player;

    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int P   = 1 + ON + OFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] seq_len = '0;
    logic [3:0] rd_sel;
    logic [2:0] rd_data;
    logic       led_on;
    logic [2:0] led_color;
    logic       busy;
    logic       done;
`ifdef SEQ_PLAYER_ABORT_EN
    logic       abort = 1'b0;
`endif

    logic [2:0] reg_file [16];
    logic [2:0] exp_q [$];
    logic       led_on_prev = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    assign rd_data = reg_file[rd_sel];

    always #5 clk = ~clk;

    seq_player #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .ADDR_W(4), .DATA_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seq_len   (seq_len),
`ifdef SEQ_PLAYER_ABORT_EN
        .abort     (abort),
`endif
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .led_on    (led_on),
        .led_color (led_color),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every newly lit colour must match the oldest queued expectation
    always @(negedge clk) begin
        if (led_on && !led_on_prev) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_light", 32'(led_color), 32'hFFFF_FFFF);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                chk("sb_color", 32'(led_color), 32'(e));
            end
        end
        led_on_prev = led_on;
    end

    task automatic push_colors(input int len);
        int n;
        n = (len > 16) ? 16 : len;
        for (int i = 0; i < n; i++) exp_q.push_back(reg_file[i]);
    endtask

    // t counts edges after the accepting edge E0; checks run #1 after each edge.
    task automatic play(input int len, input int mid_t, input int next_len,
                        input bit pre, input int stop_t);
        int n;
        n = (len > 16) ? 16 : len;
        if (!pre) begin
            @(negedge clk);
            seq_len = 5'(len);
            start   = 1'b1;
            push_colors(len);
        end
        @(posedge clk);
        #1;
        start   = 1'b0;
        seq_len = 5'($urandom_range(0, 31));
        for (int t = 0; t <= n * P + 1; t++) begin
            int       k;
            int       ph;
            bit       lit;
            bit       e_busy;
            bit       e_done;
            int       e_sel;
            logic [2:0] e_col;
            if (t > 0) begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            if (t < n * P) begin
                k      = t / P;
                ph     = t % P;
                lit    = (ph >= 1) && (ph <= ON);
                e_col  = lit ? reg_file[k] : 3'd0;
                e_busy = 1'b1;
                e_done = 1'b0;
                e_sel  = k;
            end else begin
                lit    = 1'b0;
                e_col  = 3'd0;
                e_busy = 1'b0;
                e_done = (t == n * P);
                e_sel  = (n > 0) ? n - 1 : 0;
            end
            chk($sformatf("led_on len=%0d t=%0d", len, t), 32'(led_on), 32'(lit));
            chk($sformatf("led_color len=%0d t=%0d", len, t), 32'(led_color), 32'(e_col));
            chk($sformatf("busy len=%0d t=%0d", len, t), 32'(busy), 32'(e_busy));
            chk($sformatf("done len=%0d t=%0d", len, t), 32'(done), 32'(e_done));
            chk($sformatf("rd_sel len=%0d t=%0d", len, t), 32'(rd_sel), 32'(e_sel));
            if (t == stop_t) return;
            if (t == mid_t) start = 1'b1;
            if (next_len >= 0 && t == n * P) begin
                start   = 1'b1;
                seq_len = 5'(next_len);
                push_colors(next_len);
                return;
            end
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_led_on"}, 32'(led_on), 32'd0);
        chk({tag, "_led_color"}, 32'(led_color), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_rd_sel"}, 32'(rd_sel), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) reg_file[i] = 3'(i + 3);
        reg_file[0] = 3'd5;
        reg_file[1] = 3'd1;
        reg_file[2] = 3'd7;

        #12;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("post_reset");

        // basic three-step playback
        play(3, -1, -1, 1'b0, -1);

        // zero-length request: done only
        play(0, -1, -1, 1'b0, -1);

        // oversize request clamps to 16 steps
        for (int i = 0; i < 16; i++) reg_file[i] = 3'(i & 7);
        play(20, -1, -1, 1'b0, -1);

        // start during ON of step 1 is ignored; start in the done cycle chains a new run
        reg_file[0] = 3'd5;
        reg_file[1] = 3'd1;
        reg_file[2] = 3'd7;
        reg_file[3] = 3'd2;
        play(3, 10, 2, 1'b0, -1);
        play(2, -1, -1, 1'b1, -1);

        // asynchronous reset during ON of step 1
        play(3, -1, -1, 1'b0, P + 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async_reset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_idle($sformatf("idle_after_reset%0d", i));
        end

`ifdef SEQ_PLAYER_ABORT_EN
        // abort during OFF of step 0, then a fresh run from index 0
        play(3, -1, -1, 1'b0, ON + 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_led_on", 32'(led_on), 32'd0);
        chk("abort_led_color", 32'(led_color), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        chk("abort_done_late", 32'(done), 32'd0);
        exp_q.delete();
        play(3, -1, -1, 1'b0, -1);
`endif

        @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
